// File: rtl/crc8_rx_frame_ctrl_if.sv
// Signal bundle between the RX frame sequencer and its environment.
// Carries the serial input, the CRC engine hookup and the frame results.
interface crc8_rx_frame_ctrl_if;
  logic       sof;
  logic       rx_valid;
  logic       rx_bit;
  logic       crc_clear;
  logic       crc_enable;
  logic       crc_data;
  logic [7:0] crc_value;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic [7:0] frame_len;
  logic       frame_done;
  logic       frame_ok;
  logic [1:0] frame_err;

  modport master (
    output sof,
    output rx_valid,
    output rx_bit,
    output crc_value,
    input  crc_clear,
    input  crc_enable,
    input  crc_data,
    input  byte_valid,
    input  byte_data,
    input  frame_len,
    input  frame_done,
    input  frame_ok,
    input  frame_err
  );

  modport slave (
    input  sof,
    input  rx_valid,
    input  rx_bit,
    input  crc_value,
    output crc_clear,
    output crc_enable,
    output crc_data,
    output byte_valid,
    output byte_data,
    output frame_len,
    output frame_done,
    output frame_ok,
    output frame_err
  );
endinterface

// File: rtl/crc8_rx_frame_ctrl.sv
// RX frame sequencer (LEN, payload, CRC) driving an external CRC-8 engine.
// Optional mid-frame idle timeout is enabled by defining RX_TIMEOUT_EN.
module crc8_rx_frame_ctrl #(
  parameter int unsigned MAX_LEN     = 64,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic                 clk,
  input logic                 rst_n,
  crc8_rx_frame_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CRC     = 3'd3,
    CHECK   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CRC  = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;
`ifdef RX_TIMEOUT_EN
  localparam logic [1:0] ERR_TO   = 2'b11;
`endif

  localparam logic [7:0]  MaxLen     = MAX_LEN[7:0];
`ifdef RX_TIMEOUT_EN
  localparam logic [15:0] TimeoutCyc = TIMEOUT_CYC[15:0];
`endif

  if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
    $error("MAX_LEN out of range 1..255");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYC out of range 1..65535");
  end

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic [7:0] frame_len_q, frame_len_d;
  logic       byte_valid_q, byte_valid_d;
  logic       frame_done_q, frame_done_d;
  logic       frame_ok_q, frame_ok_d;
  logic [1:0] frame_err_q, frame_err_d;
`ifdef RX_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;
`endif

  logic active;
  logic accept;

  assign active = (state_q == LEN) ||
                  (state_q == PAYLOAD) ||
                  (state_q == CRC);
  // sof clears the engine, so it must not also clock a bit in
  assign accept = bus.rx_valid & ~bus.sof & active;

  assign bus.crc_clear  = bus.sof;
  assign bus.crc_enable = accept;
  assign bus.crc_data   = bus.rx_bit;

  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_data  = byte_data_q;
  assign bus.frame_len  = frame_len_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_ok   = frame_ok_q;
  assign bus.frame_err  = frame_err_q;

  // next-state and datapath update for the frame parser
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    byte_data_d  = byte_data_q;
    frame_len_d  = frame_len_q;
    byte_valid_d = 1'b0;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    frame_err_d  = frame_err_q;
`ifdef RX_TIMEOUT_EN
    idle_d       = '0;
`endif

    if (bus.sof) begin
      state_d     = LEN;
      bit_cnt_d   = '0;
      byte_cnt_d  = '0;
      frame_ok_d  = 1'b0;
      frame_err_d = ERR_NONE;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        LEN: begin
          if (accept) begin
            frame_len_d = {frame_len_q[6:0], bus.rx_bit};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (frame_len_d > MaxLen) begin
                frame_done_d = 1'b1;
                frame_ok_d   = 1'b0;
                frame_err_d  = ERR_LEN;
                state_d      = IDLE;
              end else if (frame_len_d == 8'd0) begin
                state_d = CRC;
              end else begin
                state_d = PAYLOAD;
              end
            end
          end
        end
        PAYLOAD: begin
          if (accept) begin
            shift_d   = {shift_q[6:0], bus.rx_bit};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_data_d  = shift_d;
              byte_valid_d = 1'b1;
              byte_cnt_d   = byte_cnt_q + 8'd1;
              if (byte_cnt_d == frame_len_q) begin
                state_d = CRC;
              end
            end
          end
        end
        CRC: begin
          if (accept) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          // engine has absorbed the CRC byte; zero remainder means good
          frame_done_d = 1'b1;
          frame_ok_d   = (bus.crc_value == 8'h00);
          frame_err_d  = (bus.crc_value == 8'h00) ? ERR_NONE : ERR_CRC;
          state_d      = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase

`ifdef RX_TIMEOUT_EN
      if (active) begin
        if (bus.rx_valid) begin
          idle_d = '0;
        end else begin
          idle_d = idle_q + 16'd1;
          if (idle_d == TimeoutCyc) begin
            frame_done_d = 1'b1;
            frame_ok_d   = 1'b0;
            frame_err_d  = ERR_TO;
            state_d      = IDLE;
          end
        end
      end
`endif
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      byte_data_q  <= '0;
      frame_len_q  <= '0;
      byte_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      byte_data_q  <= byte_data_d;
      frame_len_q  <= frame_len_d;
      byte_valid_q <= byte_valid_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef RX_TIMEOUT_EN
  // idle cycle counter for the mid-frame timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

endmodule
